// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the LSU side.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int   WCNT_W    = 4;
  localparam logic CS_ACTIVE = 1'b0;
  localparam logic WR_STORE  = 1'b0;

endpackage

// File: rtl/dmem_bank.sv
// Byte-enable synchronous word array; kept apart so an SRAM macro can replace it.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first: rdata_o shows the word as it was before a same-edge write.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_o <= mem[idx_i];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave behind the LSU port: byte-masked stores, whole-word loads,
// fixed wait states, range checking against BASE_ADDR.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cs_i,
  input  logic        wr_i,
  input  logic [3:0]  mask_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_wr_i,
  output logic [31:0] data_rd_o,
  output logic        stall_o,
  output logic        valid_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              st_q, inr_q, err_q, rd_live_q;
  logic [3:0]        mask_q;
  logic [AW-1:0]     idx_q;
  logic [31:0]       wdata_q, hold_q, bank_rdata;

  logic [31:0]   off;
  logic          req, req_inr, acc;
  logic          a_st, a_inr;
  logic [3:0]    a_mask;
  logic [AW-1:0] a_idx;
  logic [31:0]   a_wdata;

  assign off     = addr_i - BASE_ADDR;
  assign req     = (state_q == IDLE) && (cs_i == CS_ACTIVE);
  assign req_inr = (off >> (AW + 2)) == 32'd0;

  // With no wait states the access edge is the request edge, so the array is
  // fed from the live request in IDLE and from the latched copy otherwise.
  assign a_st    = req ? (wr_i == WR_STORE) : st_q;
  assign a_inr   = req ? req_inr            : inr_q;
  assign a_mask  = req ? mask_i             : mask_q;
  assign a_idx   = req ? off[AW+1:2]        : idx_q;
  assign a_wdata = req ? data_wr_i          : wdata_q;
  assign acc     = rst_i && (state_d == RESP) && (state_q != RESP);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: if (req) begin
        if (WAIT_STATES > 0) begin
          state_d = WAIT;
          wcnt_d  = WCNT_W'(WAIT_STATES - 1);
        end else begin
          state_d = RESP;
        end
      end
      WAIT: if (wcnt_q == '0) state_d = RESP;
            else              wcnt_d  = wcnt_q - 1'b1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      st_q      <= 1'b0;
      inr_q     <= 1'b0;
      mask_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      rd_live_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (req) begin
        st_q    <= (wr_i == WR_STORE);
        inr_q   <= req_inr;
        mask_q  <= mask_i;
        idx_q   <= off[AW+1:2];
        wdata_q <= data_wr_i;
      end
      err_q     <= acc && !a_inr;
      rd_live_q <= acc && !a_st && a_inr;
      // Capture the bank word after RESP so data_rd survives later stores.
      if (acc && !a_inr) hold_q <= '0;
      else if (rd_live_q) hold_q <= bank_rdata;
    end
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk_i   (clk_i),
    .we_i    (acc && a_st && a_inr),
    .be_i    (a_mask),
    .idx_i   (a_idx),
    .wdata_i (a_wdata),
    .rdata_o (bank_rdata)
  );

  assign data_rd_o = rd_live_q ? bank_rdata : hold_q;
  assign stall_o   = req || (state_q == WAIT);
  assign valid_o   = (state_q == RESP);
  assign err_o     = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

- Data-memory slave that sits on the far side of the load/store unit's memory port.
- Accepts the LSU's request: active-low chip select and write strobe, byte-lane mask, word-aligned lane data, full byte address.
- Performs byte-masked writes and whole-word reads from an internal array, with a configurable number of wait states.
- Returns read data, a completion pulse and a stall to the core pipeline.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH_WORDS*4.
- WAIT_STATES, 0: extra cycles per access, 0..15.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-low.
- cs  in  1  chip select, active-low; a request is present while 0.
- wr  in  1  write strobe, active-low: 0 = store, 1 = load.
- mask  in  4  byte-lane enables for stores, bit i = data_wr[8i+7:8i].
- addr  in  32  byte address; bits [1:0] are ignored (lanes are already placed by the LSU).
- data_wr  in  32  lane-placed store data.
- data_rd  out  32  full word read; the LSU extracts and extends the byte or halfword.
- stall  out  1  high while a request is accepted but not yet complete.
- valid  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with valid when addr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If cs==0, latch addr, wr, mask and data_wr, and compute idx = (addr-BASE_ADDR)[log2(DEPTH_WORDS)+1:2] plus an in-range flag.
  - Go to WAIT when WAIT_STATES>0 (load wcnt = WAIT_STATES-1), otherwise go to RESP.
- WAIT:
  - Decrement wcnt each cycle.
  - When wcnt==0, go to RESP.
- Access edge (the edge that enters RESP):
  - Store in range: write every byte whose mask bit is 1; other bytes are unchanged.
  - Load in range: register mem[idx] into data_rd.
  - Out of range: no write, data_rd <= 0, and err is set for the RESP cycle.
- RESP:
  - valid=1, stall=0, then return to IDLE.
  - cs is not sampled in RESP; it still belongs to the completing instruction.
- stall is combinational: (state==IDLE && cs==0) || state==WAIT.
- data_rd holds its value until the next load or out-of-range access completes; stores do not change it.
- A store with mask==4'b0000 writes nothing but still completes with valid.
- Array contents are not initialised by reset. A $readmemh hook for simulation is permitted.

## Timing
- Request sampled in IDLE at cycle T. Completion (valid, data_rd, err) in cycle T+1+WAIT_STATES.
- stall is high in cycles T .. T+WAIT_STATES and low in the RESP cycle.
- Back-to-back throughput is one access every 2+WAIT_STATES cycles. The next request may present in the cycle after RESP.
- Reset values: state=IDLE, wcnt=0, data_rd=0, valid=0, err=0. stall=0 when cs=1.
- Reset asserted mid-access:
  - Returns to IDLE on that edge and the pending access is dropped.
  - A store is not performed unless that edge is itself the access edge, where reset takes priority and no write occurs.
- cs rising during WAIT is ignored: the latched request completes.
- Address wrap: addr-BASE_ADDR is computed modulo 2^32; any result >= 4*DEPTH_WORDS is out of range.

## Structure
- Package dmem_pkg holds:
  - the state typedef enum {IDLE, WAIT, RESP};
  - the wait-counter width constant (4 bits);
  - the CS_ACTIVE=1'b0 and WR_STORE=1'b0 polarity constants shared with the LSU.
- Sub-module dmem_bank (DEPTH_WORDS) is the byte-enable synchronous array.
  - Inputs: clk, we, be[3:0], idx, wdata. Output: registered rdata.
  - Separates the storage from the FSM so an SRAM macro can be swapped in.

## Test plan
- Reset with cs=1 -> data_rd=0, stall=0, valid=0. Reset held over 3 cycles with cs=0 -> no valid pulse.
- WAIT_STATES=0, store addr=0x10, data_wr=0xDEADBEEF, mask=1111, then load 0x10 -> valid at T+1 each time, data_rd=0xDEADBEEF.
- Byte store mask=0100, data_wr=0x00AA0000 over word 0x11223344, then load -> data_rd=0x11AA3344, other bytes unchanged.
- WAIT_STATES=3, load -> stall high for 4 cycles (T..T+3), valid at T+4. Toggling cs during WAIT changes nothing.
- Load addr=BASE_ADDR+4*DEPTH_WORDS -> err=1 with valid and data_rd=0. Store to the same address -> no array word changes.
- Reset asserted during WAIT of a store to 0x20 (old 0x0) -> FSM in IDLE next cycle, no valid, later load of 0x20 returns 0x0.
